// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting in front of the MEM/WB register.
// Issues one load or store at a time on the data-memory bus. Load data is
// lane-selected and sign/zero-extended here. Upstream stages are stalled while
// a transaction is in flight.
//
// Data-memory handshake: a request transfers on a rising edge where both
// dmem_req_valid and dmem_req_ready are 1. Once dmem_req_valid rises, it and
// every request field stay constant until that transfer. A read response is
// taken on a rising edge with dmem_rsp_valid = 1 while the FSM waits in RESP.
// A response seen in any other state is dropped.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses. A trapped access raises misalign / misalign_addr and issues
// no bus request.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 REQ, 2 RESP, 3 DONE.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module mem_access #(
  parameter int XLEN  = `XLEN,
  parameter int RFIDX = `RFIDX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  wdata,
  input  logic             wb_reg_write,
  input  logic             wb_memtoreg,
  input  logic [RFIDX-1:0] rd_index,
  output logic             stall,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_wstrb,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_rsp_valid,
  input  logic [XLEN-1:0]  dmem_rsp_rdata,
  output logic             out_valid,
  output logic [XLEN-1:0]  m_data,
  output logic [XLEN-1:0]  ex_result_out,
  output logic             wb_reg_write_out,
  output logic             wb_memtoreg_out,
  output logic [RFIDX-1:0] rd_index_out,
`ifdef MISALIGN_TRAP_EN
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  ex_q;
  logic [XLEN-1:0]  wd_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic             wbw_q;
  logic             m2r_q;
  logic [RFIDX-1:0] rd_q;
  logic [XLEN-1:0]  m_data_q;
  logic             mis_q;

  logic             is_mem;
  logic             in_mis;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_fmt;
  logic [3:0]       st_strb;
  logic [XLEN-1:0]  st_data;

  // An instruction counts as a memory op only when EX marks it valid.
  // If both read and write are set, the op is handled as a store.
  assign is_mem = in_valid & (mem_read | mem_write);

`ifdef MISALIGN_TRAP_EN
  // Halfword with addr[0] set, or word (funct3[1] set) with non-zero low bits.
  assign in_mis = ((funct3[1:0] == 2'b01) & ex_result[0]) |
                  (funct3[1] & (ex_result[1:0] != 2'b00));
`else
  assign in_mis = 1'b0;
`endif

  // Format the returned word. The lane comes from the captured address;
  // funct3[2] selects zero extension.
  always_comb begin
    byte_sel = dmem_rsp_rdata[{ex_q[1:0], 3'b000} +: 8];
    half_sel = dmem_rsp_rdata[{ex_q[1], 4'b0000} +: 16];
    load_fmt = dmem_rsp_rdata;
    case (f3_q[1:0])
      2'b00:   load_fmt = f3_q[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                                  : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = f3_q[2] ? {{(XLEN-16){1'b0}}, half_sel}
                                  : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: load_fmt = dmem_rsp_rdata;
    endcase
  end

  // Build store lane strobes and replicated store data from the captured op.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wd_q;
    case (f3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ex_q[1:0];
        st_data = {(XLEN/8){wd_q[7:0]}};
      end
      2'b01: begin
        st_strb = ex_q[1] ? 4'b1100 : 4'b0011;
        st_data = {(XLEN/16){wd_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wd_q;
      end
    endcase
  end

  // Sequence one access: capture it in IDLE, hold it on the bus in REQ,
  // wait for read data in RESP, and present it for one cycle in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ex_q     <= '0;
      wd_q     <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      wbw_q    <= 1'b0;
      m2r_q    <= 1'b0;
      rd_q     <= '0;
      m_data_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            ex_q     <= ex_result;
            wd_q     <= wdata;
            f3_q     <= funct3;
            we_q     <= mem_write;
            wbw_q    <= wb_reg_write;
            m2r_q    <= wb_memtoreg;
            rd_q     <= rd_index;
            m_data_q <= '0;
            mis_q    <= in_mis;
            state    <= in_mis ? DONE : REQ;
          end
        end
        REQ: begin
          if (dmem_req_ready) state <= we_q ? DONE : RESP;
        end
        RESP: begin
          if (dmem_rsp_valid) begin
            m_data_q <= load_fmt;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus request fields come only from captured registers, so they stay stable.
  always_comb begin
    dmem_req_valid = (state == REQ);
    dmem_we        = we_q;
    dmem_addr      = {ex_q[XLEN-1:2], 2'b00};
    dmem_wstrb     = we_q ? st_strb : 4'b0000;
    dmem_wdata     = st_data;
    state_dbg      = state;
  end

  // MEM/WB view. A non-memory op in IDLE passes through combinationally.
  // DONE replays the captured op. All other cases produce a bubble.
  always_comb begin
    stall            = 1'b0;
    out_valid        = 1'b0;
    m_data           = '0;
    ex_result_out    = ex_result;
    rd_index_out     = rd_index;
    wb_reg_write_out = 1'b0;
    wb_memtoreg_out  = wb_memtoreg;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall = 1'b1;
        end else begin
          out_valid        = in_valid;
          wb_reg_write_out = in_valid & wb_reg_write;
        end
      end
      REQ, RESP: begin
        stall           = 1'b1;
        ex_result_out   = ex_q;
        rd_index_out    = rd_q;
        wb_memtoreg_out = m2r_q;
      end
      DONE: begin
        out_valid        = 1'b1;
        m_data           = m_data_q;
        ex_result_out    = ex_q;
        rd_index_out     = rd_q;
        wb_reg_write_out = wbw_q & ~mis_q;
        wb_memtoreg_out  = m2r_q;
      end
      default: stall = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // The trap flag is raised only during the DONE cycle of a trapped access.
  always_comb begin
    misalign      = (state == DONE) & mis_q;
    misalign_addr = ex_q;
  end
`endif

endmodule
